// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Package : servo_pwm_pkg
// Brief   : Shared types and helpers for the multi-channel servo PWM block.
// Rev     : 1.0  initial release
// ============================================================================
package servo_pwm_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_ALT   = 1'b1;

    // Config fields are stored at a fixed width; narrower ports are zero-extended.
    localparam int CFG_FW = 16;

    typedef struct packed {
        logic              mode;
        logic [CFG_FW-1:0] width_a;
        logic [CFG_FW-1:0] width_b;
        logic [CFG_FW-1:0] dwell;
    } cfg_t;

    function automatic logic [CFG_FW-1:0] eff_dwell(input logic [CFG_FW-1:0] dwell);
        return (dwell == '0) ? CFG_FW'(1) : dwell;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_multi_prescaler.sv
`default_nettype none
// ============================================================================
// Module : pwm_prescaler
// Brief  : Divides clk into a one-cycle tick every CLK_DIV cycles while enabled.
// Rev    : 1.0  initial release
// ============================================================================
module pwm_prescaler #(
    parameter int CLK_DIV = 2400
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              c_cw   = $clog2(CLK_DIV);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

    logic [c_cw-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_cw'(1);
        end
    end

    assign tick = en && (r_div_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module : servo_pwm_multi
// Brief  : N-channel frame-based PWM with per-channel A/B width alternation.
// Rev    : 1.0  initial release
// ============================================================================
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_DIV     = 2400,
    parameter int FRAME_TICKS = 200,
    parameter int WW          = 8,
    parameter int DW          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [N_CH-1:0]    mode,
    input  logic [N_CH*WW-1:0] width_a,
    input  logic [N_CH*WW-1:0] width_b,
    input  logic [N_CH*DW-1:0] dwell,
    output logic [N_CH-1:0]    pwm,
    output logic [N_CH-1:0]    phase,
    output logic               frame_start
);

    // FRAME_TICKS <= 2**WW, so the last tick index always fits in WW bits.
    localparam logic [WW-1:0] c_last_tick = WW'(FRAME_TICKS - 1);

    logic          r_en_d;
    logic          w_run;
    logic          w_tick;
    logic          w_boundary;
    logic [WW-1:0] r_frame_cnt;
    logic [WW-1:0] w_frame_cnt_nxt;
    logic          r_frame_start;

    // Prescaler is held through the first enabled cycle so the new frame starts at div_cnt = 0.
    assign w_run = en && r_en_d;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_run),
        .tick (w_tick)
    );

    assign w_boundary = en && (!r_en_d || (w_tick && (r_frame_cnt == c_last_tick)));

    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (!en || w_boundary) begin
            w_frame_cnt_nxt = '0;
        end else if (w_tick) begin
            w_frame_cnt_nxt = r_frame_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_d        <= 1'b0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_en_d        <= en;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_frame_start <= w_boundary;
        end
    end

    assign frame_start = r_frame_start;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            cfg_t              w_in;
            cfg_t              r_pend;
            cfg_t              r_act;
            cfg_t              w_act_nxt;
            logic [DW-1:0]     r_dcnt;
            logic [DW-1:0]     w_dcnt_nxt;
            logic              r_phase;
            logic              w_phase_nxt;
            logic [CFG_FW-1:0] w_weff_nxt;
            logic              w_pwm_nxt;
            logic              r_pwm;

            always_comb begin
                w_in         = '0;
                w_in.mode    = mode[i];
                w_in.width_a = CFG_FW'(width_a[i*WW +: WW]);
                w_in.width_b = CFG_FW'(width_b[i*WW +: WW]);
                w_in.dwell   = CFG_FW'(dwell[i*DW +: DW]);
            end

            // A load coinciding with a boundary bypasses pending into the new frame.
            always_comb begin
                w_act_nxt = r_act;
                if (w_boundary) begin
                    w_act_nxt = load ? w_in : r_pend;
                end
            end

            // Dwell accounting uses the cfg of the frame that is ending; a restart,
            // or either side of the boundary being fixed-mode, starts fresh in phase A.
            always_comb begin
                w_dcnt_nxt  = r_dcnt;
                w_phase_nxt = r_phase;
                if (!en) begin
                    w_dcnt_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end else if (w_boundary) begin
                    if (!r_en_d || (r_act.mode != MODE_ALT) || (w_act_nxt.mode == MODE_FIXED)) begin
                        w_dcnt_nxt  = '0;
                        w_phase_nxt = 1'b0;
                    end else if (CFG_FW'(r_dcnt) >= (eff_dwell(r_act.dwell) - CFG_FW'(1))) begin
                        w_dcnt_nxt  = '0;
                        w_phase_nxt = !r_phase;
                    end else begin
                        w_dcnt_nxt  = r_dcnt + DW'(1);
                    end
                end
            end

            assign w_weff_nxt = w_phase_nxt ? w_act_nxt.width_b : w_act_nxt.width_a;
            assign w_pwm_nxt  = en && (CFG_FW'(w_frame_cnt_nxt) < w_weff_nxt);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend  <= '0;
                    r_act   <= '0;
                    r_dcnt  <= '0;
                    r_phase <= 1'b0;
                    r_pwm   <= 1'b0;
                end else begin
                    if (load) begin
                        r_pend <= w_in;
                    end
                    r_act   <= w_act_nxt;
                    r_dcnt  <= w_dcnt_nxt;
                    r_phase <= w_phase_nxt;
                    r_pwm   <= w_pwm_nxt;
                end
            end

            assign pwm[i]   = r_pwm;
            assign phase[i] = r_phase;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_servo_pwm_multi
// Brief  : Scoreboard bench; per-frame pulse widths and phases vs. expected queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_servo_pwm_multi;

    localparam int N_CH  = 2;
    localparam int WW    = 8;
    localparam int DW    = 8;
    localparam int FRAME = 80;  // clk cycles per frame (CLK_DIV 4 * FRAME_TICKS 20)

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               load = 1'b0;
    logic [N_CH-1:0]    mode = '0;
    logic [N_CH*WW-1:0] width_a = '0;
    logic [N_CH*WW-1:0] width_b = '0;
    logic [N_CH*DW-1:0] dwell = '0;
    logic [N_CH-1:0]    pwm;
    logic [N_CH-1:0]    phase;
    logic               frame_start;

    typedef struct {
        int w0;
        int w1;
        int p0;
        int p1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   abort_req = 0;

    servo_pwm_multi #(
        .N_CH        (N_CH),
        .CLK_DIV     (4),
        .FRAME_TICKS (20),
        .WW          (WW),
        .DW          (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .mode        (mode),
        .width_a     (width_a),
        .width_b     (width_b),
        .dwell       (dwell),
        .pwm         (pwm),
        .phase       (phase),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int w0, input int w1, input int p0, input int p1);
        exp_t e;
        e.w0 = w0; e.w1 = w1; e.p0 = p0; e.p1 = p1;
        q.push_back(e);
    endtask

    task automatic set_cfg(input int ch, input logic m, input int a, input int b, input int d);
        mode[ch]           = m;
        width_a[ch*WW +: WW] = WW'(a);
        width_b[ch*WW +: WW] = WW'(b);
        dwell[ch*DW +: DW]   = DW'(d);
    endtask

    task automatic pulse_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    // en is sampled at the next edge; frame_start must be up right after it.
    task automatic enable_and_check(input string name);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(name, int'(frame_start), 1);
    endtask

    task automatic stop_run();
        @(posedge clk); #1 en = 1'b0;
        abort_req++;
    endtask

    task automatic wait_fs(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check({name, "_frames_left"}, q.size(), 0);
            q.delete();
        end
    endtask

    // Monitor: measures each complete frame and scores it against the queue.
    initial begin
        int len, c0, c1, p0, p1, seen;
        bit in_frame;
        exp_t e;
        len = 0; c0 = 0; c1 = 0; p0 = 0; p1 = 0; seen = 0; in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (abort_req != seen) begin
                seen     = abort_req;
                in_frame = 1'b0;
            end
            if (frame_start) begin
                if (in_frame) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("frame_len", len, FRAME);
                        check("width_ch0", c0, e.w0);
                        check("width_ch1", c1, e.w1);
                        check("phase_ch0", p0, e.p0);
                        check("phase_ch1", p1, e.p1);
                    end
                end
                in_frame = 1'b1;
                len = 1;
                c0 = int'(pwm[0]); c1 = int'(pwm[1]);
                p0 = int'(phase[0]); p1 = int'(phase[1]);
            end else if (in_frame) begin
                len++;
                c0 += int'(pwm[0]);
                c1 += int'(pwm[1]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_frame_start", int'(frame_start), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: enable with no load, all channels idle
        push(0, 0, 0, 0); push(0, 0, 0, 0);
        enable_and_check("fs_first_noload");
        wait_empty("s1", 3 * FRAME);
        stop_run();

        // 2: fixed width 5 ticks on ch0
        set_cfg(0, 1'b0, 5, 0, 0); set_cfg(1, 1'b0, 0, 0, 0);
        pulse_load();
        repeat (3) push(20, 0, 0, 0);
        enable_and_check("fs_first_fixed");
        wait_empty("s2", 4 * FRAME);
        stop_run();

        // 3: ch1 alternates A=3 / B=10 with dwell 2
        set_cfg(1, 1'b1, 3, 10, 2);
        pulse_load();
        push(20, 12, 0, 0); push(20, 12, 0, 0); push(20, 40, 0, 1);
        push(20, 40, 0, 1); push(20, 12, 0, 0);
        enable_and_check("fs_first_alt");
        wait_empty("s3", 6 * FRAME);
        stop_run();

        // 4a: zero width and full-frame width
        set_cfg(0, 1'b0, 0, 0, 0); set_cfg(1, 1'b0, 20, 0, 0);
        pulse_load();
        push(0, 80, 0, 0); push(0, 80, 0, 0);
        enable_and_check("fs_first_ext_a");
        wait_empty("s4a", 3 * FRAME);
        stop_run();

        // 4b: width 255 and dwell 0 alternating between 0 and 255
        set_cfg(0, 1'b0, 255, 0, 0); set_cfg(1, 1'b1, 0, 255, 0);
        pulse_load();
        push(80, 0, 0, 0); push(80, 80, 0, 1); push(80, 0, 0, 0); push(80, 80, 0, 1);
        enable_and_check("fs_first_ext_b");
        wait_empty("s4b", 5 * FRAME);
        stop_run();

        // 4c: dwell 0 and dwell 1 both toggle every frame
        set_cfg(0, 1'b1, 20, 2, 0); set_cfg(1, 1'b1, 5, 5, 1);
        pulse_load();
        push(80, 20, 0, 0); push(8, 20, 1, 1); push(80, 20, 0, 0);
        enable_and_check("fs_first_ext_c");
        wait_empty("s4c", 4 * FRAME);
        stop_run();

        // 5a: mid-frame load 5 -> 8 takes effect at the next frame
        set_cfg(0, 1'b0, 5, 0, 0); set_cfg(1, 1'b0, 0, 0, 0);
        pulse_load();
        push(20, 0, 0, 0); push(32, 0, 0, 0); push(32, 0, 0, 0);
        enable_and_check("fs_first_mid");
        repeat (30) @(posedge clk);
        #1 set_cfg(0, 1'b0, 8, 0, 0); load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        wait_empty("s5a", 4 * FRAME);
        stop_run();

        // 5b: load on the boundary cycle applies to the new frame
        set_cfg(0, 1'b0, 5, 0, 0);
        pulse_load();
        push(20, 0, 0, 0); push(32, 0, 0, 0); push(32, 0, 0, 0);
        enable_and_check("fs_first_bnd");
        repeat (FRAME - 1) @(posedge clk);
        #1 set_cfg(0, 1'b0, 8, 0, 0); load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        wait_empty("s5b", 4 * FRAME);
        stop_run();

        // 6: reset mid-frame with pwm high and phase B
        set_cfg(0, 1'b0, 5, 0, 0); set_cfg(1, 1'b1, 3, 10, 0);
        pulse_load();
        push(20, 12, 0, 0);
        enable_and_check("fs_first_rst");
        wait_fs("s6_frame2");
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pre_rst_pwm0", int'(pwm[0]), 1);
        check("pre_rst_phase1", int'(phase[1]), 1);
        @(posedge clk); #1 rst = 1'b1; en = 1'b0; abort_req++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_pwm", int'(pwm), 0);
        check("post_rst_phase", int'(phase), 0);
        check("post_rst_frame_start", int'(frame_start), 0);

        // 6b: en dropped mid-frame, then a clean restart
        set_cfg(1, 1'b0, 0, 0, 0);
        pulse_load();
        enable_and_check("fs_first_endrop");
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_drop_pwm0", int'(pwm[0]), 1);
        stop_run();
        @(posedge clk);
        @(negedge clk);
        check("post_drop_pwm", int'(pwm), 0);
        check("post_drop_phase", int'(phase), 0);
        check("post_drop_frame_start", int'(frame_start), 0);
        push(20, 0, 0, 0); push(20, 0, 0, 0);
        enable_and_check("fs_first_reen");
        wait_empty("s6b", 3 * FRAME);
        stop_run();

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
